axis_pkt_checker: RTL

- Sink stage directly downstream of the pcap replay source.
- Consumes the data/strb/len/valid/eop stream and drives `ready` with configurable backpressure.
- Checks per-packet framing and length consistency, and accumulates packet, byte, error and inter-packet-gap statistics for bench scoreboards.
- Sits at the end of the network test bench datapath as the reference sink and protocol monitor.

---
 rtl/axis_chk_pkg.sv | 26 ++
 rtl/axis_pkt_checker_if.sv | 14 +
 rtl/axis_strb_popcount.sv | 25 ++
 rtl/axis_pkt_checker.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_chk_pkg.sv
// Shared constants and types for the AXI-stream packet checker.
// Status bit positions, LFSR taps and the framing state encoding.
package axis_chk_pkg;

    localparam int ST_W            = 7;
    localparam int ST_NONCONTIG    = 0;
    localparam int ST_PARTIAL_MID  = 1;
    localparam int ST_LEN_MISMATCH = 2;
    localparam int ST_LEN_CHANGED  = 3;
    localparam int ST_RUNT         = 4;
    localparam int ST_OVERSIZE     = 5;
    localparam int ST_ZERO_STRB    = 6;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: taps at bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/axis_pkt_checker_if.sv
// Stream bundle between the pcap replay source and the packet checker sink.
interface axis_pkt_checker_if #(
    parameter int AXIS_WIDTH = 512
);
    logic [AXIS_WIDTH-1:0]   data;
    logic [AXIS_WIDTH/8-1:0] strb;
    logic [47:0]             len;
    logic                    valid;
    logic                    eop;
    logic                    ready;

    modport master (output data, strb, len, valid, eop, input ready);
    modport slave  (input data, strb, len, valid, eop, output ready);
endinterface

// File: rtl/axis_strb_popcount.sv
// Combinational byte count and shape classification of a strobe mask.
module axis_strb_popcount #(
    parameter int STRB_W = 64,
    parameter int CNT_W  = $clog2(STRB_W + 1)
) (
    input  logic [STRB_W-1:0] i_strb,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_contig,
    output logic              o_all_ones,
    output logic              o_zero
);

    always_comb begin
        o_count = '0;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            o_count = o_count + CNT_W'(i_strb[i]);
        end
    end

    // A mask of the form 2^k-1 has no carry overlap with itself plus one.
    assign o_contig   = ((i_strb & (i_strb + STRB_W'(1))) == '0);
    assign o_all_ones = &i_strb;
    assign o_zero     = ~|i_strb;

endmodule

// File: rtl/axis_pkt_checker.sv
// Reference sink and protocol monitor: drives backpressure, checks packet
// framing/length and accumulates packet, byte, error and gap statistics.
module axis_pkt_checker
    import axis_chk_pkg::*;
#(
    parameter int          AXIS_WIDTH = 512,
    parameter int          BP_MODE    = 0,
    parameter int          BP_THRESH  = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          MIN_PKT    = 60,
    parameter int          MAX_PKT    = 9600
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_clr,
    axis_pkt_checker_if.slave s_axis,
    output logic             o_pkt_done,
    output logic [15:0]      o_pkt_bytes,
    output logic [ST_W-1:0]  o_pkt_status,
    output logic [31:0]      o_pkt_count,
    output logic [63:0]      o_byte_count,
    output logic [31:0]      o_err_count,
    output logic [ST_W-1:0]  o_err_sticky,
    output logic [31:0]      o_min_gap,
    output logic [31:0]      o_max_gap
);

    localparam int          STRB_W   = AXIS_WIDTH / 8;
    localparam int          CNT_W    = $clog2(STRB_W + 1);
    localparam logic [16:0] MIN_B    = 17'(MIN_PKT);
    localparam logic [16:0] MAX_B    = 17'(MAX_PKT);
    localparam logic [4:0]  THRESH_B = 5'(BP_THRESH);

    state_e            r_state;
    logic [15:0]       r_lfsr;
    logic              r_ready;
    logic [16:0]       r_acc;
    logic [47:0]       r_len_q;
    logic [ST_W-1:0]   r_st;
    logic              r_pkt_done;
    logic [15:0]       r_pkt_bytes;
    logic [ST_W-1:0]   r_pkt_status;
    logic [31:0]       r_pkt_count;
    logic [63:0]       r_byte_count;
    logic [31:0]       r_err_count;
    logic [ST_W-1:0]   r_err_sticky;
    logic [31:0]       r_min_gap;
    logic [31:0]       r_max_gap;
    logic [31:0]       r_gap;
    logic              r_gap_vld;

    logic [CNT_W-1:0]  w_cnt;
    logic              w_contig;
    logic              w_all_ones;
    logic              w_zero;
    logic              w_accept;
    logic              w_sop;
    logic              w_eop;
    logic [16:0]       w_base;
    logic [17:0]       w_sum;
    logic [16:0]       w_bytes;
    logic [47:0]       w_len_ref;
    logic [ST_W-1:0]   w_st_beat;
    logic [ST_W-1:0]   w_st_pkt;
    logic [ST_W-1:0]   w_st_final;

    axis_strb_popcount #(
        .STRB_W (STRB_W),
        .CNT_W  (CNT_W)
    ) u_popcount (
        .i_strb     (s_axis.strb),
        .o_count    (w_cnt),
        .o_contig   (w_contig),
        .o_all_ones (w_all_ones),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_accept  = s_axis.valid && r_ready;
        w_sop     = w_accept && (r_state == IDLE);
        w_eop     = w_accept && s_axis.eop;
        w_base    = w_sop ? '0 : r_acc;
        w_sum     = {1'b0, w_base} + 18'(w_cnt);
        w_bytes   = w_sum[17] ? '1 : w_sum[16:0];
        // A single-beat packet must compare against the len it carries itself.
        w_len_ref = w_sop ? s_axis.len : r_len_q;

        w_st_beat                 = '0;
        w_st_beat[ST_NONCONTIG]   = !w_contig;
        w_st_beat[ST_PARTIAL_MID] = !s_axis.eop && !w_all_ones;
        w_st_beat[ST_LEN_CHANGED] = !w_sop && (s_axis.len != r_len_q);
        w_st_beat[ST_ZERO_STRB]   = w_zero;
        w_st_pkt                  = (w_sop ? '0 : r_st) | w_st_beat;

        w_st_final                  = w_st_pkt;
        w_st_final[ST_LEN_MISMATCH] = (48'(w_bytes) != w_len_ref);
        w_st_final[ST_RUNT]         = (w_bytes < MIN_B);
        w_st_final[ST_OVERSIZE]     = (w_bytes > MAX_B);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr  <= LFSR_SEED;
            r_ready <= 1'b0;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
            if (BP_MODE == 0) begin
                r_ready <= i_enable;
            end else begin
                r_ready <= i_enable && ({1'b0, r_lfsr[3:0]} >= THRESH_B);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_acc        <= '0;
            r_len_q      <= '0;
            r_st         <= '0;
            r_pkt_done   <= 1'b0;
            r_pkt_bytes  <= '0;
            r_pkt_status <= '0;
        end else begin
            r_pkt_done <= w_eop;
            if (w_accept) begin
                r_acc <= w_bytes;
                r_st  <= w_st_pkt;
                if (w_sop) begin
                    r_len_q <= s_axis.len;
                end
                case (r_state)
                    IDLE:    if (!s_axis.eop) r_state <= IN_PKT;
                    IN_PKT:  if (s_axis.eop)  r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
            if (w_eop) begin
                r_pkt_bytes  <= (w_bytes > 17'h0FFFF) ? 16'hFFFF : w_bytes[15:0];
                r_pkt_status <= w_st_final;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pkt_count  <= '0;
            r_byte_count <= '0;
            r_err_count  <= '0;
            r_err_sticky <= '0;
            r_min_gap    <= '1;
            r_max_gap    <= '0;
            r_gap        <= '0;
            r_gap_vld    <= 1'b0;
        end else if (i_clr) begin
            r_pkt_count  <= '0;
            r_byte_count <= '0;
            r_err_count  <= '0;
            r_err_sticky <= '0;
            r_min_gap    <= '1;
            r_max_gap    <= '0;
            r_gap        <= '0;
            r_gap_vld    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_byte_count <= r_byte_count + 64'(w_cnt);
            end
            if (w_eop) begin
                r_pkt_count  <= r_pkt_count + 32'd1;
                r_err_sticky <= r_err_sticky | w_st_final;
                if (|w_st_final) begin
                    r_err_count <= r_err_count + 32'd1;
                end
            end
            // A single-beat packet closes the old gap here and reopens it below.
            if (w_sop && r_gap_vld) begin
                if (r_gap < r_min_gap) r_min_gap <= r_gap;
                if (r_gap > r_max_gap) r_max_gap <= r_gap;
            end
            if (w_eop) begin
                r_gap     <= '0;
                r_gap_vld <= 1'b1;
            end else if ((r_state == IDLE) && !w_accept && (r_gap != '1)) begin
                r_gap <= r_gap + 32'd1;
            end
        end
    end

    assign s_axis.ready = r_ready;
    assign o_pkt_done   = r_pkt_done;
    assign o_pkt_bytes  = r_pkt_bytes;
    assign o_pkt_status = r_pkt_status;
    assign o_pkt_count  = r_pkt_count;
    assign o_byte_count = r_byte_count;
    assign o_err_count  = r_err_count;
    assign o_err_sticky = r_err_sticky;
    assign o_min_gap    = r_min_gap;
    assign o_max_gap    = r_max_gap;

endmodule
